// File: rtl/mux_scan_ctrl_if.sv
// Bundle of control inputs, mux feedback and scan results for mux_scan_ctrl.
// The master side drives the controls; the slave side is the scan controller.
interface mux_scan_ctrl_if;
   logic       start;
   logic       hold;
   logic       abort;
   logic       mux_m;
   logic [1:0] sel;
   logic [3:0] samples;
   logic       sample_valid;
   logic       busy;
   logic       done;

   modport master (
      output start, hold, abort, mux_m,
      input  sel, samples, sample_valid, busy, done
   );

   modport slave (
      input  start, hold, abort, mux_m,
      output sel, samples, sample_valid, busy, done
   );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Steps a 4:1 mux select through all channels, dwelling DWELL cycles on each before sampling.
// Define MUX_SCAN_CONTINUOUS_EN to wrap back to channel 0 instead of ending after one pass.
module mux_scan_ctrl #(
   parameter int unsigned DWELL = 4,
   parameter int unsigned CW    = 8
) (
   input logic            clock,
   input logic            resetn,
   mux_scan_ctrl_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StDwell, StCapture, StDone} state_e;

   localparam logic [CW-1:0] CntLast = CW'(DWELL - 1);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    sel_q, sel_d;
   logic [3:0]    samples_q, samples_d;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         sel_q     <= 2'd0;
         samples_q <= 4'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sel_q     <= sel_d;
         samples_q <= samples_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sel_d     = sel_q;
      samples_d = samples_q;

      // abort wins over everything, including the capture itself
      if (bus.abort) begin
         state_d = StIdle;
         cnt_d   = '0;
         sel_d   = 2'd0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.start) begin
                  state_d = StDwell;
                  cnt_d   = '0;
                  sel_d   = 2'd0;
               end
            end
            StDwell: begin
               if (!bus.hold) begin
                  if (cnt_q == CntLast) begin
                     state_d = StCapture;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
            StCapture: begin
               samples_d[sel_q] = bus.mux_m;
               cnt_d            = '0;
               if (sel_q != 2'd3) begin
                  state_d = StDwell;
                  sel_d   = sel_q + 2'd1;
               end else begin
`ifdef MUX_SCAN_CONTINUOUS_EN
                  state_d = StDwell;
`else
                  state_d = StDone;
`endif
                  sel_d   = 2'd0;
               end
            end
            StDone: begin
               state_d = StIdle;
               sel_d   = 2'd0;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   assign bus.sel          = sel_q;
   assign bus.samples      = samples_q;
   assign bus.sample_valid = (state_q == StCapture);
   assign bus.busy         = (state_q == StDwell) || (state_q == StCapture);
   assign bus.done         = (state_q == StDone);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl (single-pass build): a cycle table for one full pass,
// then hand sequences for hold, abort, DWELL=1 back-to-back passes and asynchronous reset.
module tb_mux_scan_ctrl;

   logic clock = 1'b0;
   logic resetn;
   always #5 clock = ~clock;

   mux_scan_ctrl_if bus ();
   mux_scan_ctrl_if bus1 ();

   // mux_mode: 0 = table-driven value, 1 = tied to sel[0], 2 = tied to ~sel[0]
   logic [1:0] mux_mode;
   logic       mux_drv;
   assign bus.mux_m  = (mux_mode == 2'd0) ? mux_drv :
                       (mux_mode == 2'd1) ? bus.sel[0] : ~bus.sel[0];
   assign bus1.mux_m = bus1.sel[0];

   mux_scan_ctrl #(.DWELL(4), .CW(8)) u_dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   mux_scan_ctrl #(.DWELL(1), .CW(8)) u_dut1 (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus1)
   );

   typedef struct packed {
      logic       start;
      logic       hold;
      logic       abort;
      logic       mux_m;
      logic [1:0] sel;
      logic [3:0] samples;
      logic       valid;
      logic       busy;
      logic       done;
   } vec_t;

   localparam int NVec = 23;
   vec_t vecs [NVec];

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [8:0] outs(input logic [1:0] s, input logic [3:0] smp,
                                       input logic v, input logic b, input logic d);
      return {s, smp, v, b, d};
   endfunction

   int   p;
   int   pch;
   int   done_at;
   int   ch1_len;
   logic seen;
   logic [15:0] seq;

   initial begin
      resetn   = 1'b0;
      mux_mode = 2'd0;
      mux_drv  = 1'b0;
      bus.start = 1'b0; bus.hold = 1'b0; bus.abort = 1'b0;
      bus1.start = 1'b0; bus1.hold = 1'b0; bus1.abort = 1'b0;

      // Vector k: inputs present before edge k, outputs expected just after it.
      // Edge 0 leaves IDLE; channel ch occupies cycles 5ch..5ch+4 (last is CAPTURE); DONE at 20.
      for (int k = 0; k < NVec; k++) begin
         vecs[k]       = '0;
         vecs[k].start = (k == 0) || (k == 7) || (k == 21);
         if (k > 0) begin
            p   = k - 1;
            pch = p / 5;
            // channel value only in its capture cycle, opposite value while dwelling
            if (p < 20) vecs[k].mux_m = (p % 5 == 4) ? pch[0] : ~pch[0];
         end
         if (k < 20) begin
            vecs[k].sel   = 2'(k / 5);
            vecs[k].busy  = 1'b1;
            vecs[k].valid = (k % 5 == 4);
         end
         vecs[k].done    = (k == 20);
         vecs[k].samples = {k >= 20, 1'b0, k >= 10, 1'b0};
      end

      #2;
      check("reset_state", 32'(outs(bus.sel, bus.samples, bus.sample_valid, bus.busy, bus.done)),
            32'd0);
      #10 resetn = 1'b1;
      step();

      // Full pass, start pulsed mid-pass and in DONE (both ignored)
      for (int k = 0; k < NVec; k++) begin
         bus.start = vecs[k].start;
         bus.hold  = vecs[k].hold;
         bus.abort = vecs[k].abort;
         mux_drv   = vecs[k].mux_m;
         step();
         check($sformatf("vec%0d", k),
               32'(outs(bus.sel, bus.samples, bus.sample_valid, bus.busy, bus.done)),
               32'(outs(vecs[k].sel, vecs[k].samples, vecs[k].valid, vecs[k].busy,
                        vecs[k].done)));
      end
      bus.start = 1'b0;

      // Hold for 3 cycles mid-dwell on channel 1: channel lasts 8, DONE at 23
      mux_mode  = 2'd2;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      done_at   = -1;
      ch1_len   = 0;
      for (int c = 1; c <= 40 && done_at < 0; c++) begin
         bus.hold = (c >= 7 && c <= 9);
         step();
         if (bus.sel == 2'd1 && bus.busy) ch1_len++;
         if (bus.done) done_at = c;
      end
      bus.hold = 1'b0;
      check("hold_done_cycle", 32'(done_at), 32'd23);
      check("hold_ch1_len", 32'(ch1_len), 32'd8);
      check("hold_samples", 32'(bus.samples), 32'h5);
      step();

      // Abort during CAPTURE of channel 2, together with start and hold
      mux_mode  = 2'd1;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      repeat (14) step();
      check("abort_pre", 32'({bus.sel, bus.sample_valid, bus.samples}), 32'({2'd2, 1'b1, 4'h6}));
      bus.abort = 1'b1;
      bus.start = 1'b1;
      bus.hold  = 1'b1;
      step();
      check("abort_idle",
            32'(outs(bus.sel, bus.samples, bus.sample_valid, bus.busy, bus.done)),
            32'(outs(2'd0, 4'h6, 1'b0, 1'b0, 1'b0)));
      step();
      check("abort_over_start", 32'({bus.busy, bus.sel}), 32'd0);
      bus.abort = 1'b0;
      bus.start = 1'b0;
      bus.hold  = 1'b0;
      seen = 1'b0;
      repeat (6) begin
         step();
         if (bus.done || bus.busy) seen = 1'b1;
      end
      check("abort_quiet", 32'(seen), 32'd0);

      // DWELL=1 with start held: 2 cycles per channel, DONE at 8, one IDLE, then restart
      bus1.start = 1'b1;
      step();
      seq     = {14'd0, bus1.sel};
      done_at = -1;
      for (int c = 1; c <= 20 && done_at < 0; c++) begin
         step();
         if (c <= 7) seq = {seq[13:0], bus1.sel};
         if (bus1.done) done_at = c;
      end
      check("d1_sel_seq", 32'(seq), 32'h05AF);
      check("d1_done_cycle", 32'(done_at), 32'd8);
      step();
      check("d1_idle_gap", 32'({bus1.busy, bus1.done, bus1.sel}), 32'd0);
      step();
      check("d1_restart", 32'({bus1.busy, bus1.sel}), 32'({1'b1, 2'd0}));

      // Asynchronous reset between edges mid-pass
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      repeat (7) step();
      #3 resetn = 1'b0;
      #1;
      check("async_rst_dut",
            32'(outs(bus.sel, bus.samples, bus.sample_valid, bus.busy, bus.done)), 32'd0);
      check("async_rst_dut1",
            32'(outs(bus1.sel, bus1.samples, bus1.sample_valid, bus1.busy, bus1.done)), 32'd0);
      bus1.start = 1'b0;
      #2 resetn = 1'b1;
      seen = 1'b0;
      repeat (5) begin
         step();
         if (bus.busy || bus.done || bus.sel != 2'd0 || bus.samples != 4'd0) seen = 1'b1;
      end
      check("post_rst_quiet", 32'(seen), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 The block SHALL have parameter DWELL, default 4: cycles sel is held on a channel before capture; legal range 1..255.
REQ-002 The block SHALL have parameter CW, default 8: dwell counter width; CW SHALL satisfy 2^CW > DWELL.
REQ-003 clock  in  1  single rising-edge clock for all state.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  begins a scan pass when sampled high in IDLE.
REQ-006 hold  in  1  freezes the dwell counter while high.
REQ-007 abort  in  1  returns the FSM to IDLE from any state.
REQ-008 mux_m  in  1  output of the downstream 4:1 mux, fed back.
REQ-009 sel  out  2  mux select; sel[0]=S0, sel[1]=S1; registered.
REQ-010 samples  out  4  samples[i] = last captured mux_m for channel i; registered.
REQ-011 sample_valid  out  1  high during the CAPTURE cycle only.
REQ-012 busy  out  1  high in DWELL and CAPTURE.
REQ-013 done  out  1  one-cycle pulse at end of pass.

Function
REQ-014 The FSM SHALL have four states: IDLE, DWELL, CAPTURE, DONE; all outputs SHALL be Moore (state/register driven).
REQ-015 IDLE: sel=0, busy=0; start=1 and abort=0 -> DWELL with counter=0 and sel=0.
REQ-016 DWELL: counter increments by 1 each cycle while hold=0 and holds while hold=1; when counter==DWELL-1 and hold=0, the next state SHALL be CAPTURE.
REQ-017 CAPTURE (exactly one cycle, hold ignored): samples[sel] SHALL load mux_m at the closing edge; other samples bits SHALL be unchanged.
REQ-018 CAPTURE with sel<3: next state DWELL, sel<=sel+1, counter<=0.
REQ-019 CAPTURE with sel==3: next state per REQ-027/REQ-028.
REQ-020 DONE: done=1, busy=0, sel=0; next state SHALL be IDLE unconditionally; start in DONE SHALL be ignored.
REQ-021 Timing: each channel SHALL take DWELL+1 cycles with hold=0; a full pass SHALL take 4*(DWELL+1) cycles from first DWELL cycle to DONE.
REQ-022 start while busy SHALL be ignored; a pass SHALL NOT restart.
REQ-023 abort=1 SHALL force IDLE at the next edge from any state, with priority over start, hold and capture; sel<=0, counter<=0; samples SHALL be retained; no capture SHALL occur in that cycle.
REQ-024 The counter SHALL never exceed DWELL-1; no wrap-around SHALL be reachable.
REQ-025 samples SHALL persist across passes and SHALL change only at CAPTURE or reset.

Reset
REQ-026 resetn=0 SHALL immediately force state=IDLE, counter=0, sel=0, samples=0, sample_valid=0, busy=0, done=0, independent of clock; release SHALL take effect at the next rising edge.

Configuration
REQ-027 With macro MUX_SCAN_CONTINUOUS_EN defined, CAPTURE at sel==3 SHALL go to DWELL with sel<=0, counter<=0; DONE SHALL be unreachable and done SHALL stay 0; the scan SHALL run until abort or reset.
REQ-028 Without MUX_SCAN_CONTINUOUS_EN, CAPTURE at sel==3 SHALL go to DONE (single pass).

Verification
REQ-029 DWELL=4, mux_m tied to sel[0], pulse start -> sel steps 0,1,2,3 every 5 cycles; samples=4'b1010; done pulses once 20 cycles after first DWELL cycle.
REQ-030 DWELL=4, hold=1 for 3 cycles mid-dwell on channel 1 -> channel 1 lasts 8 cycles; pass totals 23 cycles; samples unaffected by hold.
REQ-031 abort=1 during CAPTURE of channel 2 -> next cycle IDLE, sel=0, samples[2] not updated, done never pulses.
REQ-032 DWELL=1, start held high continuously -> each channel 2 cycles, done at cycle 8, IDLE one cycle, then new pass starts.
REQ-033 resetn=0 asserted between clock edges mid-pass -> all outputs 0 immediately; after release, no activity until start.
REQ-034 With MUX_SCAN_CONTINUOUS_EN, DWELL=2 -> sel sequence 0,1,2,3,0,1 repeats every 12 cycles; done stays 0; abort stops scan.
